// File: rtl/fpa_top_if.sv
// fpa_top_if: operand/result bundle for the binary32 multiplier
interface fpa_top_if;
  logic [31:0] number_A;
  logic [31:0] number_B;
  logic [31:0] number_out;
  modport master(output number_A, output number_B, input number_out);
  modport slave(input number_A, input number_B, output number_out);
endinterface

// File: rtl/fpa_top.sv
// fpa_top: IEEE-754 binary32 multiplier, round-to-nearest-even, one registered cycle
module fpa_top (
  input logic      clk,
  input logic      rst_n,
  fpa_top_if.slave bus
);
  logic [7:0] ea, eb, exa, exb;
  logic [22:0] ma, mb;
  logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [23:0] sig_a, sig_b;
  logic [47:0] mult_mantis, w;
  logic [95:0] ext;
  logic [5:0] lz;
  logic signed [11:0] e, en, sh;
  logic [6:0] rs;
  logic norm, sticky, rnd;
  logic [9:0] ef;
  logic [32:0] sum;
  logic [31:0] res;
  assign ea = bus.number_A[30:23];
  assign eb = bus.number_B[30:23];
  assign ma = bus.number_A[22:0];
  assign mb = bus.number_B[22:0];
  assign s = bus.number_A[31] ^ bus.number_B[31];
  assign a_nan = (ea == 8'hFF) && (ma != 23'd0);
  assign b_nan = (eb == 8'hFF) && (mb != 23'd0);
  assign a_inf = (ea == 8'hFF) && (ma == 23'd0);
  assign b_inf = (eb == 8'hFF) && (mb == 23'd0);
  assign a_zero = (ea == 8'd0) && (ma == 23'd0);
  assign b_zero = (eb == 8'd0) && (mb == 23'd0);
  assign sig_a = {ea != 8'd0, ma};
  assign sig_b = {eb != 8'd0, mb};
  assign exa = (ea == 8'd0) ? 8'd1 : ea;
  assign exb = (eb == 8'd0) ? 8'd1 : eb;
  assign mult_mantis = 48'(sig_a) * 48'(sig_b);
  always_comb begin
    lz = 6'd0;
    for (int i = 0; i < 48; i++) if (mult_mantis[i]) lz = 6'(47 - i);
  end
  // e is the biased exponent if the leading one sat at bit 47; subnormal results pin it to 1
  always_comb begin
    e = $signed({4'b0, exa}) + $signed({4'b0, exb}) - 12'sd126;
    en = e - $signed({6'b0, lz});
    norm = en > 12'sd0;
    sh = norm ? $signed({6'b0, lz}) : e - 12'sd1;
    rs = (sh >= 12'sd0) ? 7'd0 : (-sh > 12'sd48) ? 7'd48 : 7'(-sh);
    ext = {mult_mantis, 48'd0} >> rs;
    w = (sh < 12'sd0) ? ext[95:48] : mult_mantis << sh;
    sticky = (|ext[47:0]) | (|w[21:0]);
    rnd = w[23] & (w[22] | sticky | w[24]);
    ef = norm ? 10'(en - 12'sd1) : 10'd0;
    sum = {ef, 23'd0} + {9'd0, w[47:24]} + 33'(rnd);
  end
  always_comb
    res = a_nan ? (bus.number_A | 32'h0040_0000) :
          b_nan ? (bus.number_B | 32'h0040_0000) :
          ((a_inf & b_zero) | (a_zero & b_inf)) ? 32'hFFC0_0000 :
          (a_inf | b_inf) ? {s, 8'hFF, 23'd0} :
          (a_zero | b_zero) ? {s, 31'd0} :
          (sum[32:23] >= 10'd255) ? {s, 8'hFF, 23'd0} : {s, sum[30:0]};
  always_ff @(posedge clk)
    if (!rst_n) bus.number_out <= 32'd0;
    else bus.number_out <= res;
endmodule

// File: tb/tb_fpa_top.sv
// tb_fpa_top: checks fpa_top against an exact double-precision reference with RNE conversion
module tb_fpa_top;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  fpa_top_if bus();
  fpa_top dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic is_nan(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  endfunction
  function automatic logic is_inf(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  endfunction
  function automatic logic is_zero(input logic [31:0] a);
    return a[30:0] == 31'd0;
  endfunction
  function automatic real mag(input logic [31:0] a);
    int e;
    e = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    return real'(int'({a[30:23] != 8'd0, a[22:0]})) * (2.0 ** real'(e - 150));
  endfunction

  // exact product in double, then rounded to binary32 quanta (2^-149 floor for subnormals)
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic s;
    logic [63:0] d, sig, u, rem, half;
    int ee, q, dr, ex;
    s = a[31] ^ b[31];
    if (is_nan(a)) return a | 32'h0040_0000;
    if (is_nan(b)) return b | 32'h0040_0000;
    if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return 32'hFFC0_0000;
    if (is_inf(a) || is_inf(b)) return {s, 8'hFF, 23'd0};
    if (is_zero(a) || is_zero(b)) return {s, 31'd0};
    d = $realtobits(mag(a) * mag(b));
    ee = int'(d[62:52]) - 1023;
    sig = {11'd0, 1'b1, d[51:0]};
    q = ((ee < -126) ? -126 : ee) - 23;
    dr = q - (ee - 52);
    if (dr >= 54) u = 64'd0;
    else begin
      u = sig >> dr;
      rem = sig - (u << dr);
      half = 64'd1 << (dr - 1);
      if (rem > half || (rem == half && u[0])) u = u + 64'd1;
    end
    if (q == -149) return {s, u[30:0]};
    ex = ee + 127;
    if (u == (64'd1 << 24)) begin
      u = u >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {s, 8'hFF, 23'd0};
    return {s, ex[7:0], u[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    int c;
    logic s;
    logic [22:0] m;
    c = int'($urandom_range(0, 7));
    s = 1'($urandom);
    m = 23'($urandom);
    if (c == 0) return {s, 31'd0};
    if (c == 1) return {s, 8'd0, (m == 23'd0) ? 23'd1 : m};
    if (c == 2) return {s, 8'hFF, 23'd0};
    if (c == 3) return {s, 8'hFF, (m == 23'd0) ? 23'd5 : m};
    if (c == 4) return {s, 8'($urandom_range(1, 254)), m};
    if (c == 5) return {s, 8'($urandom_range(100, 154)), m};
    if (c == 6) return {s, ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 40)) : 8'($urandom_range(200, 254)), m};
    return 32'($urandom);
  endfunction

  // every edge: the output 1ns later must be the product of the operands sampled at that edge
  always @(posedge clk) begin
    logic [31:0] want;
    want = rst_n ? model(bus.number_A, bus.number_B) : 32'd0;
    #1;
    checks++;
    if (bus.number_out !== want) begin
      failures++;
      $display("FAIL stream t=%0t a=%h b=%h rst_n=%b got=%h want=%h", $time, bus.number_A, bus.number_B, rst_n, bus.number_out, want);
    end
  end

  localparam int ND = 17;
  logic [31:0] da [ND] = '{32'h3FC00000, 32'hC0400000, 32'h00000001, 32'h00000001, 32'h00800000, 32'h00400000,
                           32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 32'h80000000, 32'h00000000, 32'h80000000,
                           32'h7F800001, 32'h3F800000, 32'h7FC00002, 32'h00FFFFFF, 32'h3F800001};
  logic [31:0] db [ND] = '{32'h40000000, 32'h3F000000, 32'h3F800000, 32'h3F000000, 32'h3F000000, 32'h40000000,
                           32'h40000000, 32'hC0000000, 32'h7F800000, 32'h3F800000, 32'h7F800000, 32'hFF800000,
                           32'h3F800000, 32'hFF812345, 32'h7FC00003, 32'h3F000000, 32'h3F800001};
  logic [31:0] dw [ND] = '{32'h40400000, 32'hBFC00000, 32'h00000001, 32'h00000000, 32'h00400000, 32'h00800000,
                           32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h80000000, 32'hFFC00000, 32'hFFC00000,
                           32'h7FC00001, 32'hFFC12345, 32'h7FC00002, 32'h00800000, 32'h3F800002};

  initial begin
    bus.number_A = 32'h3FC00000;
    bus.number_B = 32'h40000000;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.number_out !== 32'd0) begin
      failures++;
      $display("FAIL reset got=%h want=00000000", bus.number_out);
    end
    for (int i = 0; i < ND; i++) begin
      rst_n = 1'b1;
      bus.number_A = da[i];
      bus.number_B = db[i];
      checks++;
      if (model(da[i], db[i]) !== dw[i]) begin
        failures++;
        $display("FAIL model%0d got=%h want=%h", i, model(da[i], db[i]), dw[i]);
      end
      @(posedge clk);
      #2;
      checks++;
      if (bus.number_out !== dw[i]) begin
        failures++;
        $display("FAIL dir%0d a=%h b=%h got=%h want=%h", i, da[i], db[i], bus.number_out, dw[i]);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    bus.number_A = 32'h3FC00000;
    bus.number_B = 32'h40000000;
    @(posedge clk);
    #2;
    checks++;
    if (bus.number_out !== 32'd0) begin
      failures++;
      $display("FAIL midreset got=%h want=00000000", bus.number_out);
    end
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 59) != 0);
      bus.number_A = rnd_op();
      bus.number_B = rnd_op();
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
